// File: rtl/alt_vipcts131_arb_pkg.sv
// Shared types and constants for the two-input packet arbiter.
package alt_vipcts131_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic IN0 = 1'b0;
  localparam logic IN1 = 1'b1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IN0  = 2'b01;
  localparam logic [1:0] GRANT_IN1  = 2'b10;

  function automatic logic [1:0] grant_onehot(input arb_state_e st);
    case (st)
      ST_GRANT0: grant_onehot = GRANT_IN0;
      ST_GRANT1: grant_onehot = GRANT_IN1;
      default:   grant_onehot = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alt_vipcts131_common_stream_output_reg.sv
// Single registered valid/ready stage; accepts a new beat whenever empty or draining.
module alt_vipcts131_common_stream_output_reg #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  sop_q;
  logic                  eop_q;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      sop_q   <= in_sop;
      eop_q   <= in_eop;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alt_vipcts131_common_packet_arbiter.sv
// Two-input packet arbiter holding the grant from sop to eop; round-robin by default,
// fixed priority to input 0 when ALT_VIPCTS131_ARB_FIXED_PRIO_EN is defined.
module alt_vipcts131_common_packet_arbiter
  import alt_vipcts131_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din0_valid,
  input  logic [DATA_WIDTH-1:0] din0_data,
  input  logic                  din0_sop,
  input  logic                  din0_eop,
  output logic                  din0_ready,
  input  logic                  din1_valid,
  input  logic [DATA_WIDTH-1:0] din1_data,
  input  logic                  din1_sop,
  input  logic                  din1_eop,
  output logic                  din1_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop,
  input  logic                  dout_ready,
  output logic [1:0]            grant,
  output logic                  drop0,
  output logic                  drop1
);

  arb_state_e            state_q, state_d;
  logic                  stage_ready;
  logic                  stage_valid;
  logic [DATA_WIDTH-1:0] stage_data;
  logic                  stage_sop;
  logic                  stage_eop;
  logic                  req0, req1;
  logic                  acc_eop0, acc_eop1;
  logic                  tie_to_in1;

  assign req0     = din0_valid & din0_sop;
  assign req1     = din1_valid & din1_sop;
  assign acc_eop0 = (state_q == ST_GRANT0) & din0_valid & stage_ready & din0_eop;
  assign acc_eop1 = (state_q == ST_GRANT1) & din1_valid & stage_ready & din1_eop;

`ifdef ALT_VIPCTS131_ARB_FIXED_PRIO_EN
  assign tie_to_in1 = 1'b0;
`else
  logic last_grant_q, last_grant_d;
  // The input that did not win last time takes the tie.
  assign tie_to_in1 = (last_grant_q == IN0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
`ifndef ALT_VIPCTS131_ARB_FIXED_PRIO_EN
      last_grant_q <= IN1;
`endif
    end else begin
      state_q <= state_d;
`ifndef ALT_VIPCTS131_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
`ifndef ALT_VIPCTS131_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = tie_to_in1 ? ST_GRANT1 : ST_GRANT0;
        else if (req0)    state_d = ST_GRANT0;
        else if (req1)    state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (acc_eop0) begin
          state_d = ST_IDLE;
`ifndef ALT_VIPCTS131_ARB_FIXED_PRIO_EN
          last_grant_d = IN0;
`endif
        end
      end
      ST_GRANT1: begin
        if (acc_eop1) begin
          state_d = ST_IDLE;
`ifndef ALT_VIPCTS131_ARB_FIXED_PRIO_EN
          last_grant_d = IN1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    din0_ready  = 1'b0;
    din1_ready  = 1'b0;
    drop0       = 1'b0;
    drop1       = 1'b0;
    stage_valid = 1'b0;
    stage_data  = din0_data;
    stage_sop   = din0_sop;
    stage_eop   = din0_eop;
    case (state_q)
      ST_GRANT0: begin
        din0_ready  = stage_ready;
        stage_valid = din0_valid;
      end
      ST_GRANT1: begin
        din1_ready  = stage_ready;
        stage_valid = din1_valid;
        stage_data  = din1_data;
        stage_sop   = din1_sop;
        stage_eop   = din1_eop;
      end
      default: ;
    endcase
    // Non-granted mid-packet beats are swallowed so a broken producer cannot stall.
    if (state_q != ST_GRANT0 && din0_valid && !din0_sop) begin
      din0_ready = 1'b1;
      drop0      = 1'b1;
    end
    if (state_q != ST_GRANT1 && din1_valid && !din1_sop) begin
      din1_ready = 1'b1;
      drop1      = 1'b1;
    end
    if (rst) begin
      din0_ready  = 1'b0;
      din1_ready  = 1'b0;
      drop0       = 1'b0;
      drop1       = 1'b0;
      stage_valid = 1'b0;
    end
  end

  assign grant = grant_onehot(state_q);

  alt_vipcts131_common_stream_output_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (stage_valid),
    .in_data  (stage_data),
    .in_sop   (stage_sop),
    .in_eop   (stage_eop),
    .in_ready (stage_ready),
    .out_valid(dout_valid),
    .out_data (dout_data),
    .out_sop  (dout_sop),
    .out_eop  (dout_eop),
    .out_ready(dout_ready)
  );

endmodule
